// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_arb_pkg
//  Purpose : Shared definitions for the data-memory port arbiter: FSM state
//            encoding, beat/word geometry and grant identifiers.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    // Default geometry: one 256-bit vector = 8 beats of 4-byte words.
    localparam int BEATS      = 8;
    localparam int WORD_BYTES = 4;

    // Identifiers held in the round-robin "last grant" register.
    localparam logic GRANT_S = 1'b0;
    localparam logic GRANT_V = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_S_ISSUE = 3'd1,
        ST_S_CAPT  = 3'd2,
        ST_S_DONE  = 3'd3,
        ST_V_ISSUE = 3'd4,
        ST_V_CAPT  = 3'd5,
        ST_V_DONE  = 3'd6
    } arb_state_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arb2
//  Purpose : Two-way round-robin arbiter (scalar vs vector). Grants are
//            combinational; the last-grant register only advances when the
//            owner accepts a grant (i_update) so priority flips per access.
//  Ports   : clk, rst      clock / asynchronous active-high reset
//            i_reqS/i_reqV request from scalar / vector side
//            i_update      grant is being consumed this cycle
//            o_grantS/V    one-hot (or zero) grant
//  Rev     : 1.0  initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_reqS,
    input  logic i_reqV,
    input  logic i_update,
    output logic o_grantS,
    output logic o_grantV
);

    logic r_lastGrant;

    // A lone requester always wins; on a tie the side that did not win last
    // time gets the port.
    always_comb begin
        o_grantS = i_reqS & (~i_reqV | (r_lastGrant == GRANT_V));
        o_grantV = i_reqV & (~i_reqS | (r_lastGrant == GRANT_S));
    end

    // Reset value VEC makes the scalar side win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastGrant <= GRANT_V;
        end else if (i_update && (o_grantS || o_grantV)) begin
            r_lastGrant <= o_grantV ? GRANT_V : GRANT_S;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : mem_port_arbiter
//  Purpose : Shares one 32-bit synchronous-read data-memory port between the
//            scalar pipeline (32-bit ld/st) and the vector pipeline
//            (256-bit vld/vst split into sequential word beats).
//  Ports   : clk, rst                  clock / async active-high reset
//            s_req/s_we/s_addr/s_wdata scalar request (held until s_ack)
//            s_rdata, s_ack, s_stall   scalar load data, done pulse, stall
//            v_req/v_we/v_addr/v_wdata vector request (held until v_ack)
//            v_rdata, v_ack, v_stall   vector load data, done pulse, stall
//            mem_en/we/addr/wdata      memory command (one source at a time)
//            mem_rdata                 memory read data, one cycle after mem_en
//            busy                      an access is in flight
//  Rev     : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = WORD_BYTES * 8,
    parameter int VEC_W  = BEATS * WORD_BYTES * 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // scalar side
    input  logic              s_req,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_ack,
    output logic              s_stall,
    // vector side
    input  logic              v_req,
    input  logic              v_we,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic [VEC_W-1:0]  v_wdata,
    output logic [VEC_W-1:0]  v_rdata,
    output logic              v_ack,
    output logic              v_stall,
    // memory port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int NUM_BEATS = VEC_W / DATA_W;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int WORD_LSB  = $clog2(DATA_W / 8);
    localparam int VEC_LSB   = $clog2(VEC_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    logic [BEAT_W-1:0] r_beat;
    logic [BEAT_W-1:0] r_capIdx;
    logic              r_capVld;
    logic              w_grantS;
    logic              w_grantV;
    logic              w_inIdle;
    logic [ADDR_W-1:0] w_sWordAddr;
    logic [ADDR_W-1:0] w_vBase;
    logic [ADDR_W-1:0] w_beatOff;
    logic              w_unused;

    // Sub-word / sub-vector address bits are ignored by design.
    assign w_unused = ^{s_addr[WORD_LSB-1:0], v_addr[VEC_LSB-1:0]};

    assign w_inIdle = (r_state == ST_IDLE);

    rr_arb2 u_rrArb (
        .clk      (clk),
        .rst      (rst),
        .i_reqS   (s_req),
        .i_reqV   (v_req),
        .i_update (w_inIdle),
        .o_grantS (w_grantS),
        .o_grantV (w_grantV)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grantS) begin
                    w_nextState = ST_S_ISSUE;
                end else if (w_grantV) begin
                    w_nextState = ST_V_ISSUE;
                end
            end
            ST_S_ISSUE: w_nextState = ST_S_CAPT;
            ST_S_CAPT:  w_nextState = ST_S_DONE;
            ST_S_DONE:  w_nextState = ST_IDLE;
            ST_V_ISSUE: begin
                if (r_beat == LAST_BEAT) begin
                    w_nextState = ST_V_CAPT;
                end
            end
            ST_V_CAPT:  w_nextState = ST_V_DONE;
            ST_V_DONE:  w_nextState = ST_IDLE;
            default:    w_nextState = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat counter and read-data capture pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
        end else if (r_state == ST_V_ISSUE) begin
            r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BEAT_W'(1);
        end else if (r_state == ST_V_DONE) begin
            r_beat <= '0;
        end
    end

    // The RAM answers one cycle after the command, so the beat index is
    // delayed by one cycle to steer each returning word into its lane. The
    // final beat lands during V_CAPT through this same path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_capVld <= 1'b0;
            r_capIdx <= '0;
        end else begin
            r_capVld <= (r_state == ST_V_ISSUE);
            r_capIdx <= r_beat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_rdata <= '0;
        end else if (r_capVld) begin
            v_rdata[r_capIdx*DATA_W +: DATA_W] <= mem_rdata;
        end
    end

    // Captured on stores too; the value is simply not meaningful then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rdata <= '0;
        end else if (r_state == ST_S_CAPT) begin
            s_rdata <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Memory command: decoded from state only, so an asynchronous reset
    // removes mem_en in the same cycle.
    // ------------------------------------------------------------------
    assign w_sWordAddr = {s_addr[ADDR_W-1:WORD_LSB], {WORD_LSB{1'b0}}};
    assign w_vBase     = {v_addr[ADDR_W-1:VEC_LSB], {VEC_LSB{1'b0}}};
    assign w_beatOff   = ADDR_W'(r_beat) << WORD_LSB;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_S_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = s_we;
                mem_addr  = w_sWordAddr;
                mem_wdata = s_wdata;
            end
            ST_V_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = v_we;
                mem_addr  = w_vBase + w_beatOff;   // wraps mod 2^ADDR_W
                mem_wdata = v_wdata[r_beat*DATA_W +: DATA_W];
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake / status
    // ------------------------------------------------------------------
    assign s_ack   = (r_state == ST_S_DONE);
    assign v_ack   = (r_state == ST_V_DONE);
    assign s_stall = s_req & ~s_ack;
    assign v_stall = v_req & ~v_ack;
    assign busy    = ~w_inIdle;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_port_arbiter
//  Purpose : Self-checking bench for mem_port_arbiter: a table of single
//            transactions plus hand-written sequences for arbitration,
//            reset mid-vector and early request drop. A behavioural
//            synchronous-read RAM sits on the memory port.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic         clk;
    logic         rst;
    logic         s_req, s_we, s_ack, s_stall;
    logic [31:0]  s_addr, s_wdata, s_rdata;
    logic         v_req, v_we, v_ack, v_stall;
    logic [31:0]  v_addr;
    logic [255:0] v_wdata, v_rdata;
    logic         mem_en, mem_we, busy;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;

    int nTests = 0;
    int nFail  = 0;

    mem_port_arbiter #(.DATA_W(32), .VEC_W(256), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_req     (s_req),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_ack     (s_ack),
        .s_stall   (s_stall),
        .v_req     (v_req),
        .v_we      (v_we),
        .v_addr    (v_addr),
        .v_wdata   (v_wdata),
        .v_rdata   (v_rdata),
        .v_ack     (v_ack),
        .v_stall   (v_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1 KiB synchronous-read RAM; preloaded while reset is held.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (rst) begin
            ram[8'h04] <= 32'hDEADBEEF;
            for (int k = 0; k < 8; k++) ram[8'h10 + k] <= 32'hA0 + k;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[9:2]];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Comparison helpers
    // ---------------------------------------------------------------
    task automatic chk1(input string name, input logic act, input logic exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Vector whose word k is base+k.
    function automatic logic [255:0] seqVec(input logic [31:0] base);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = base + k;
        return r;
    endfunction

    // ---------------------------------------------------------------
    // One transaction, started in an IDLE cycle (cycle 0) at posedge+1.
    // Checks every memory beat, stall, ack timing and load data.
    // dropAt > 0 deasserts req after sampling that cycle.
    // ---------------------------------------------------------------
    task automatic runTxn(input bit vec, input bit we, input logic [31:0] addr,
                          input logic [31:0] data, input int expAck, input int dropAt,
                          input string name);
        bit          seenAck;
        bit          reqNow;
        bit          expEn;
        logic [31:0] expAddr;
        logic [31:0] expData;
        logic        ack;
        logic        otherAck;
        logic        stall;
        if (vec) begin
            v_req = 1'b1; v_we = we; v_addr = addr; v_wdata = seqVec(data);
        end else begin
            s_req = 1'b1; s_we = we; s_addr = addr; s_wdata = data;
        end
        reqNow  = 1'b1;
        seenAck = 1'b0;
        for (int cyc = 1; cyc <= expAck + 2 && !seenAck; cyc++) begin
            tick();
            expEn = vec ? (cyc >= 1 && cyc <= 8) : (cyc == 1);
            chk1($sformatf("%s c%0d mem_en", name, cyc), mem_en, expEn);
            if (expEn) begin
                expAddr = vec ? ((addr & ~32'h1F) + 32'(4 * (cyc - 1))) : (addr & ~32'h3);
                expData = vec ? (data + 32'(cyc - 1)) : data;
                chk32($sformatf("%s c%0d mem_addr", name, cyc), mem_addr, expAddr);
                chk1($sformatf("%s c%0d mem_we", name, cyc), mem_we, we);
                if (we) chk32($sformatf("%s c%0d mem_wdata", name, cyc), mem_wdata, expData);
            end
            ack      = vec ? v_ack : s_ack;
            otherAck = vec ? s_ack : v_ack;
            stall    = vec ? v_stall : s_stall;
            chk1($sformatf("%s c%0d ack", name, cyc), ack, (cyc == expAck));
            chk1($sformatf("%s c%0d other ack", name, cyc), otherAck, 1'b0);
            chk1($sformatf("%s c%0d stall", name, cyc), stall, reqNow && (cyc != expAck));
            if (ack) begin
                seenAck = 1'b1;
                if (!we) begin
                    if (vec) chk256({name, " v_rdata"}, v_rdata, seqVec(data));
                    else     chk32({name, " s_rdata"}, s_rdata, data);
                end
            end
            if (cyc == dropAt) begin
                if (vec) v_req = 1'b0; else s_req = 1'b0;
                reqNow = 1'b0;
            end
        end
        if (!seenAck) begin
            nTests++;
            nFail++;
            $display("FAIL %s timeout: no ack within %0d cycles", name, expAck + 2);
        end
        s_req = 1'b0;
        v_req = 1'b0;
        tick();   // back in IDLE
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // ---------------------------------------------------------------
    // Transaction table
    // ---------------------------------------------------------------
    typedef struct {
        bit          vec;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;    // store data / expected load data (word k = data+k)
        int          ack;     // expected ack cycle
    } txn_t;

    txn_t tbl [9];

    int sAck1, sAck2, vAck;

    initial begin
        tbl[0] = '{vec: 1'b0, we: 1'b0, addr: 32'h10,  data: 32'hDEADBEEF, ack: 3};
        tbl[1] = '{vec: 1'b1, we: 1'b0, addr: 32'h47,  data: 32'hA0,       ack: 10};
        tbl[2] = '{vec: 1'b1, we: 1'b1, addr: 32'h40,  data: 32'h1,        ack: 10};
        tbl[3] = '{vec: 1'b1, we: 1'b0, addr: 32'h5F,  data: 32'h1,        ack: 10};
        tbl[4] = '{vec: 1'b0, we: 1'b1, addr: 32'h123, data: 32'h12345678, ack: 3};
        tbl[5] = '{vec: 1'b0, we: 1'b0, addr: 32'h122, data: 32'h12345678, ack: 3};
        tbl[6] = '{vec: 1'b1, we: 1'b1, addr: 32'h3E0, data: 32'h100,      ack: 10};
        tbl[7] = '{vec: 1'b1, we: 1'b0, addr: 32'h3FF, data: 32'h100,      ack: 10};
        tbl[8] = '{vec: 1'b0, we: 1'b0, addr: 32'h3FC, data: 32'h107,      ack: 3};

        s_req = 0; s_we = 0; s_addr = 0; s_wdata = 0;
        v_req = 0; v_we = 0; v_addr = 0; v_wdata = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("reset s_ack", s_ack, 1'b0);
        chk1("reset v_ack", v_ack, 1'b0);
        chk1("reset mem_en", mem_en, 1'b0);
        chk1("reset mem_we", mem_we, 1'b0);
        chk1("reset busy", busy, 1'b0);
        chk32("reset s_rdata", s_rdata, 32'h0);
        chk256("reset v_rdata", v_rdata, 256'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            runTxn(tbl[i].vec, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].ack, 0,
                   $sformatf("txn%0d", i));
        end

        // Simultaneous requests after reset, both held: scalar, vector, scalar.
        doReset();
        s_req = 1; s_we = 0; s_addr = 32'h10;
        v_req = 1; v_we = 0; v_addr = 32'h40;
        sAck1 = -1; sAck2 = -1; vAck = -1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            chk1($sformatf("rr c%0d dual ack", c), s_ack & v_ack, 1'b0);
            if (c == 4) chk1("rr c4 mem_en idle", mem_en, 1'b0);
            if (c == 5) begin
                chk1("rr c5 mem_en", mem_en, 1'b1);
                chk32("rr c5 mem_addr", mem_addr, 32'h40);
            end
            if (s_ack) begin
                if (sAck1 < 0) begin
                    sAck1 = c;
                    chk32("rr s_rdata", s_rdata, 32'hDEADBEEF);
                end else if (sAck2 < 0) begin
                    sAck2 = c;
                    s_req = 0;
                end
            end
            if (v_ack) begin
                if (vAck < 0) vAck = c;
                chk256("rr v_rdata", v_rdata, seqVec(32'hA0));
                v_req = 0;
            end
        end
        s_req = 0; v_req = 0;
        chk32("rr first s_ack cycle", sAck1, 32'd3);
        chk32("rr v_ack cycle", vAck, 32'd14);
        chk32("rr second s_ack cycle", sAck2, 32'd18);

        // Reset during vector beat 3.
        v_req = 1; v_we = 1; v_addr = 32'h80; v_wdata = seqVec(32'hB0);
        for (int c = 1; c <= 4; c++) tick();
        chk1("rstmid beat3 mem_en", mem_en, 1'b1);
        chk32("rstmid beat3 mem_addr", mem_addr, 32'h8C);
        rst = 1'b1;
        #1;
        chk1("rstmid mem_en async", mem_en, 1'b0);
        chk1("rstmid busy async", busy, 1'b0);
        chk1("rstmid v_ack", v_ack, 1'b0);
        v_req = 0; v_we = 0;
        repeat (2) begin
            tick();
            chk1("rstmid held v_ack", v_ack, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk1("rstmid after busy", busy, 1'b0);
        chk1("rstmid after v_ack", v_ack, 1'b0);
        // Beat 2 (0x88) was written before the reset and stays written.
        runTxn(1'b0, 1'b0, 32'h88, 32'hB2, 3, 0, "rstmid load");

        // Scalar store with s_req dropped at cycle 2 still completes.
        runTxn(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 3, 2, "drop store");
        runTxn(1'b0, 1'b0, 32'h200, 32'hCAFEF00D, 3, 0, "drop readback");
        chk1("final busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
